// File: rtl/reflet_regfile_ctrl_pkg.sv
// Shared constants for the Reflet register file core: register indices, sp_op codes, FSM states.
package reflet_regfile_ctrl_pkg;

  // Dedicated register indices (all fit in the minimum 8-entry file)
  localparam int unsigned WR_ID = 0;
  localparam int unsigned SR_ID = 5;
  localparam int unsigned PC_ID = 6;
  localparam int unsigned SP_ID = 7;

  // Stack pointer operations; 2'b11 is reserved and behaves as none
  localparam logic [1:0] SP_OP_NONE = 2'b00;
  localparam logic [1:0] SP_OP_PUSH = 2'b01;
  localparam logic [1:0] SP_OP_POP  = 2'b10;
  localparam logic [1:0] SP_OP_RSVD = 2'b11;

  // Sequencer states
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/reflet_regfile_ctrl_if.sv
// Request/response bundle between the execution units and the register file core.
interface reflet_regfile_ctrl_if #(
  parameter int unsigned WORDSIZE  = 16,
  parameter int unsigned NREG      = 16,
  parameter int unsigned INT_DEPTH = 4
);
  localparam int unsigned IDXW = $clog2(NREG);
  localparam int unsigned DEPW = $clog2(INT_DEPTH) + 1;

  logic                stall;
  logic                wr_en;
  logic [IDXW-1:0]     wr_idx;
  logic [WORDSIZE-1:0] wr_data;
  logic [1:0]          sp_op;
  logic                sp_addr;
  logic                int_take;
  logic [WORDSIZE-1:0] int_vector;
  logic                int_ret;
  logic                quit_req;
  logic                resume;
  logic [IDXW-1:0]     rd_idx;
  logic [WORDSIZE-1:0] rd_data;
  logic [WORDSIZE-1:0] wr_reg;
  logic [WORDSIZE-1:0] sr_reg;
  logic [WORDSIZE-1:0] pc_reg;
  logic [WORDSIZE-1:0] sp_reg;
  logic                halted;
  logic [DEPW-1:0]     int_depth;
  logic                int_overflow;

  modport master (
    output stall, wr_en, wr_idx, wr_data, sp_op, sp_addr, int_take, int_vector,
           int_ret, quit_req, resume, rd_idx,
    input  rd_data, wr_reg, sr_reg, pc_reg, sp_reg, halted, int_depth, int_overflow
  );

  modport slave (
    input  stall, wr_en, wr_idx, wr_data, sp_op, sp_addr, int_take, int_vector,
           int_ret, quit_req, resume, rd_idx,
    output rd_data, wr_reg, sr_reg, pc_reg, sp_reg, halted, int_depth, int_overflow
  );

endinterface

// File: rtl/reflet_regfile_ctrl_stack.sv
// Interrupt return-address LIFO; push/pop requests beyond full/empty are ignored.
module reflet_int_pc_stack #(
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WORDSIZE-1:0]             push_data,
  output logic [WORDSIZE-1:0]             top_c,
  output logic                            full_c,
  output logic                            empty_c,
  output logic [$clog2(DEPTH):0]          depth
);
  localparam int unsigned DEPW = $clog2(DEPTH) + 1;

  logic [WORDSIZE-1:0] mem_q [DEPTH];
  logic [WORDSIZE-1:0] mem_d [DEPTH];
  logic [DEPW-1:0]     cnt_q, cnt_d;

  assign full_c  = (cnt_q == DEPW'(DEPTH));
  assign empty_c = (cnt_q == '0);
  assign depth   = cnt_q;

  // Next-state: write at the current count on push, decrement on pop
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (DEPW'(i) == cnt_q) mem_d[i] = push_data;
      end
      cnt_d = cnt_q + DEPW'(1);
    end else if (pop && !empty_c) begin
      cnt_d = cnt_q - DEPW'(1);
    end
  end

  // Most recently pushed entry
  always_comb begin
    top_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (DEPW'(i + 1) == cnt_q) top_c = mem_q[i];
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/reflet_regfile_ctrl.sv
// Reflet register file and sequencing core: registers, SP stride, PC update, RUN/HALT FSM.
module reflet_regfile_ctrl #(
  parameter int unsigned         WORDSIZE  = 16,
  parameter int unsigned         NREG      = 16,
  parameter logic [WORDSIZE-1:0] PC_RESET  = '0,
  parameter logic [WORDSIZE-1:0] SP_RESET  = '0,
  parameter int unsigned         INT_DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  reflet_regfile_ctrl_if.slave bus
);
  import reflet_regfile_ctrl_pkg::*;

  localparam int unsigned   IDXW    = $clog2(NREG);
  localparam int unsigned   BYTES   = WORDSIZE / 8;
  localparam int unsigned   STRIDE4 = min_u(4, BYTES);
  localparam int unsigned   STRIDE2 = min_u(2, BYTES);
  localparam logic [IDXW-1:0] WR_IDX = IDXW'(WR_ID);
  localparam logic [IDXW-1:0] SR_IDX = IDXW'(SR_ID);
  localparam logic [IDXW-1:0] PC_IDX = IDXW'(PC_ID);
  localparam logic [IDXW-1:0] SP_IDX = IDXW'(SP_ID);

  logic [WORDSIZE-1:0] regs_q [NREG];
  logic [WORDSIZE-1:0] regs_d [NREG];
  logic [0:0]          state_q, state_d;
  logic                ovf_q, ovf_d;
  logic                push_c, pop_c, full_c, empty_c;
  logic [WORDSIZE-1:0] top_c, stride_c, sp_next_c, pc_inc_c;

  reflet_int_pc_stack #(.WORDSIZE(WORDSIZE), .DEPTH(INT_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .pop       (pop_c),
    .push_data (regs_q[PC_IDX]),
    .top_c     (top_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .depth     (bus.int_depth)
  );

  // SP stride: address-sized for call/ret, otherwise selected by sr[2:1]
  always_comb begin
    stride_c = WORDSIZE'(BYTES);
    if (!bus.sp_addr) begin
      case (regs_q[SR_IDX][2:1])
        2'b00:   stride_c = WORDSIZE'(BYTES);
        2'b01:   stride_c = WORDSIZE'(STRIDE4);
        2'b10:   stride_c = WORDSIZE'(STRIDE2);
        default: stride_c = WORDSIZE'(1);
      endcase
    end
  end

  // SP after the requested operation, wrapping modulo 2^WORDSIZE
  always_comb begin
    sp_next_c = regs_q[SP_IDX];
    case (bus.sp_op)
      SP_OP_PUSH: sp_next_c = regs_q[SP_IDX] + stride_c;
      SP_OP_POP:  sp_next_c = regs_q[SP_IDX] - stride_c;
      default:    sp_next_c = regs_q[SP_IDX];
    endcase
  end

  assign pc_inc_c = regs_q[PC_IDX] + WORDSIZE'(1);

  // Sequencer: interrupt entry/return, halt, and normal register update
  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    ovf_d   = ovf_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    if (!bus.stall) begin
      if (state_q == ST_RUN) begin
        if (bus.int_take && !full_c) begin
          push_c         = 1'b1;
          regs_d[PC_IDX] = bus.int_vector;
        end else if (!bus.int_take && bus.int_ret) begin
          if (!empty_c) begin
            pop_c          = 1'b1;
            regs_d[PC_IDX] = top_c;
          end else begin
            regs_d[PC_IDX] = pc_inc_c;
          end
        end else if (!bus.int_take && bus.quit_req) begin
          regs_d[PC_IDX] = pc_inc_c;
          state_d        = ST_HALT;
        end else begin
          if (bus.int_take) ovf_d = 1'b1;
          regs_d[SP_IDX] = sp_next_c;
          regs_d[PC_IDX] = pc_inc_c;
          if (bus.wr_en) regs_d[bus.wr_idx] = bus.wr_data;
        end
      end else begin
        if (bus.int_take && !full_c) begin
          push_c         = 1'b1;
          regs_d[PC_IDX] = bus.int_vector;
          state_d        = ST_RUN;
        end else if (bus.resume) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        if (i == int'(PC_ID))      regs_q[i] <= PC_RESET;
        else if (i == int'(SP_ID)) regs_q[i] <= SP_RESET;
        else                       regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.rd_data      = regs_q[bus.rd_idx];
  assign bus.wr_reg       = regs_q[WR_IDX];
  assign bus.sr_reg       = regs_q[SR_IDX];
  assign bus.pc_reg       = regs_q[PC_IDX];
  assign bus.sp_reg       = regs_q[SP_IDX];
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.int_overflow = ovf_q;

endmodule
